// File: rtl/pwm_meter_if.sv
// Measurement bus of the PWM meter: enable and waveform in, registered
// period/high-time results and status out.
`timescale 1ns/1ps
interface pwm_meter_if #(
  parameter int W = 16
);
  logic         en;
  logic         pwm_in;
  logic [W-1:0] period;
  logic [W-1:0] high;
  logic         valid;
  logic         ovf;
  logic         busy;

  modport master (output en, pwm_in, input period, high, valid, ovf, busy);
  modport slave  (input en, pwm_in, output period, high, valid, ovf, busy);
endinterface

// File: rtl/pwm_meter.sv
// Measures period and high time of a PWM waveform, one registered result
// with a single-cycle valid strobe per completed cycle.
`timescale 1ns/1ps
module pwm_meter #(
  parameter int W           = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        rst,
  pwm_meter_if.slave bus
);
  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;
  logic                   sync;
  logic                   rise;
  logic                   fall;
  logic [W-1:0]           per_cnt;
  logic [W-1:0]           hi_cnt;
  logic [W-1:0]           period;
  logic [W-1:0]           high;
  logic                   valid;
  logic                   ovf;
  logic                   busy;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == MAX) ? v : v + ONE;
  endfunction

  assign sync = sync_p0[SYNC_STAGES-1];
  assign rise = sync & ~prev_p1;
  assign fall = ~sync & prev_p1;

  // Stage p0: synchronizer chain; stage p1: previous level for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      prev_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], bus.pwm_in};
      prev_p1 <= sync;
    end
  end

  // Measurement FSM; results and strobe registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      per_cnt <= '0;
      hi_cnt  <= '0;
      period  <= '0;
      high    <= '0;
      ovf     <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!bus.en) begin
        state   <= IDLE;
        busy    <= 1'b0;
        per_cnt <= '0;
        hi_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state   <= HIGH;
              busy    <= 1'b1;
              per_cnt <= ONE;
              hi_cnt  <= ONE;
            end else begin
              per_cnt <= '0;
              hi_cnt  <= '0;
            end
          end
          HIGH, LOW: begin
            if (rise && state == LOW) begin
              period  <= per_cnt;
              high    <= hi_cnt;
              ovf     <= 1'b0;
              valid   <= 1'b1;
              state   <= HIGH;
              per_cnt <= ONE;
              hi_cnt  <= ONE;
            end else if (per_cnt == MAX) begin
              // In HIGH hi_cnt tracks per_cnt, so it already reads MAX there
              period  <= MAX;
              high    <= hi_cnt;
              ovf     <= 1'b1;
              valid   <= 1'b1;
              state   <= IDLE;
              busy    <= 1'b0;
              per_cnt <= '0;
              hi_cnt  <= '0;
            end else begin
              per_cnt <= sat_inc(per_cnt);
              if (state == HIGH) begin
                if (fall) state <= LOW;
                else      hi_cnt <= sat_inc(hi_cnt);
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.period = period;
  assign bus.high   = high;
  assign bus.valid  = valid;
  assign bus.ovf    = ovf;
  assign bus.busy   = busy;
endmodule

// File: tb/tb_pwm_meter.sv
// Bench for pwm_meter: timestamp-based reference model checked every cycle,
// plus directed waveforms with hand-computed results.
`timescale 1ns/1ps
module tb_pwm_meter;
  localparam int     W    = 16;
  localparam int     NS   = 2;
  localparam longint MAXL = (longint'(1) << W) - 1;

  logic clk = 1'b0;
  logic rst;

  pwm_meter_if #(.W(W)) bus();
  pwm_meter #(.W(W), .SYNC_STAGES(NS)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int     p;
    int     h;
    bit     o;
    longint c;
  } res_t;

  int     checks = 0;
  int     errors = 0;
  bit     chk_on = 1'b0;
  res_t   res_q[$];
  longint ncyc = 0;

  // Reference model: edge times in clock cycles, seen through the input delay
  logic         hist [0:NS];
  bit           m_active = 1'b0;
  bit           m_fell = 1'b0;
  longint       m_t0 = 0, m_tf = 0, cyc = 0;
  logic [W-1:0] m_period = '0, m_high = '0;
  logic         m_valid = 1'b0, m_ovf = 1'b0;

  initial begin
    forever begin : mdl
      logic   rs, fl;
      longint age;
      @(posedge clk);
      rs = hist[NS-1] & ~hist[NS];
      fl = ~hist[NS-1] & hist[NS];
      cyc++;
      m_valid = 1'b0;
      if (rst) begin
        for (int i = 0; i <= NS; i++) hist[i] = 1'b0;
        m_active = 1'b0;
        m_period = '0;
        m_high   = '0;
        m_ovf    = 1'b0;
      end else begin
        if (!bus.en) begin
          m_active = 1'b0;
        end else if (!m_active) begin
          if (rs) begin
            m_active = 1'b1;
            m_t0     = cyc;
            m_fell   = 1'b0;
          end
        end else begin
          age = cyc - m_t0;
          if (rs) begin
            m_valid  = 1'b1;
            m_period = W'(age);
            m_high   = W'(m_tf - m_t0);
            m_ovf    = 1'b0;
            m_t0     = cyc;
            m_fell   = 1'b0;
          end else if (age == MAXL) begin
            m_valid  = 1'b1;
            m_period = W'(MAXL);
            m_high   = (m_fell || fl) ? W'((m_fell ? m_tf : cyc) - m_t0) : W'(MAXL);
            m_ovf    = 1'b1;
            m_active = 1'b0;
          end else if (fl) begin
            m_tf   = cyc;
            m_fell = 1'b1;
          end
        end
        for (int i = NS; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = bus.pwm_in;
      end
    end
  end

  // Per-cycle comparison against the model, and result capture
  initial begin
    bit prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (chk_on) begin
        checks++;
        if ({bus.valid, bus.ovf, bus.busy, bus.period, bus.high} !==
            {m_valid, m_ovf, m_active, m_period, m_high}) begin
          errors++;
          $display("FAIL outputs t=%0t got v=%b o=%b b=%b p=%0d h=%0d want v=%b o=%b b=%b p=%0d h=%0d",
                   $time, bus.valid, bus.ovf, bus.busy, bus.period, bus.high,
                   m_valid, m_ovf, m_active, m_period, m_high);
        end
        if (bus.valid === 1'b1) begin
          checks++;
          if (prev_v) begin
            errors++;
            $display("FAIL valid_width t=%0t got two-cycle valid want single-cycle", $time);
          end
          res_q.push_back('{p: int'(bus.period), h: int'(bus.high), o: bus.ovf, c: ncyc});
        end
        prev_v = (bus.valid === 1'b1);
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL timeout got no finish want finish before 1500000ns");
    $fatal(1, "timeout");
  end

  task automatic hold(input logic lvl, input int n);
    bus.pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    res_q.delete();
  endtask

  task automatic expect_res(input string name, input int p, input int h, input bit o,
                            output longint c);
    res_t r;
    checks++;
    c = 0;
    if (res_q.size() == 0) begin
      errors++;
      $display("FAIL %s got no result want p=%0d h=%0d o=%0d", name, p, h, o);
    end else begin
      r = res_q.pop_front();
      c = r.c;
      if (r.p != p || r.h != h || r.o != o) begin
        errors++;
        $display("FAIL %s got p=%0d h=%0d o=%0d want p=%0d h=%0d o=%0d",
                 name, r.p, r.h, r.o, p, h, o);
      end
    end
  endtask

  task automatic expect_count(input string name, input int n);
    checks++;
    if (res_q.size() != n) begin
      errors++;
      $display("FAIL %s got %0d results want %0d", name, res_q.size(), n);
    end
  endtask

  task automatic async_set(input logic lvl, input int n);
    repeat (n) @(negedge clk);
    #($urandom_range(1, 4));
    bus.pwm_in = lvl;
  endtask

  initial begin
    longint c, cprev;
    int     hi, lo;
    rst        = 1'b1;
    bus.en     = 1'b1;
    bus.pwm_in = 1'b0;
    @(negedge clk);
    chk_on = 1'b1;
    checks++;
    if ({bus.valid, bus.ovf, bus.busy, bus.period, bus.high} !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b o=%b b=%b p=%0d h=%0d want all 0",
               bus.valid, bus.ovf, bus.busy, bus.period, bus.high);
    end
    rst = 1'b0;

    // 3 high / 5 low: period 8, high 3, valid every 8 cycles
    hold(1'b0, 4);
    repeat (7) begin hold(1'b1, 3); hold(1'b0, 5); end
    hold(1'b0, 4);
    expect_count("p8_count", 6);
    expect_res("p8_first", 8, 3, 1'b0, cprev);
    for (int i = 0; i < 5; i++) begin
      expect_res("p8_repeat", 8, 3, 1'b0, c);
      checks++;
      if (c - cprev != 8) begin
        errors++;
        $display("FAIL p8_spacing got %0d want 8", c - cprev);
      end
      cprev = c;
    end

    // Duty sweep at period 100
    do_reset();
    hold(1'b0, 10);
    hold(1'b1, 1);  hold(1'b0, 99);
    hold(1'b1, 50); hold(1'b0, 50);
    hold(1'b1, 99); hold(1'b0, 1);
    hold(1'b1, 1);  hold(1'b0, 8);
    expect_res("duty_1", 100, 1, 1'b0, c);
    expect_res("duty_50", 100, 50, 1'b0, c);
    expect_res("duty_99", 100, 99, 1'b0, c);

    // Saturation in LOW, then recovery
    do_reset();
    hold(1'b0, 5);
    hold(1'b1, 10);
    hold(1'b0, 65600);
    expect_res("sat_result", 65535, 10, 1'b1, c);
    expect_count("sat_single", 0);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL sat_idle got busy=%b want 0", bus.busy);
    end
    repeat (3) begin hold(1'b1, 4); hold(1'b0, 4); end
    hold(1'b0, 4);
    expect_res("sat_recover_a", 8, 4, 1'b0, c);
    expect_res("sat_recover_b", 8, 4, 1'b0, c);

    // Enable dropped in LOW: gap period never reported
    do_reset();
    hold(1'b0, 3);
    hold(1'b1, 4); hold(1'b0, 4);
    hold(1'b1, 4); hold(1'b0, 6);
    bus.en = 1'b0;
    hold(1'b0, 10);
    bus.en = 1'b1;
    hold(1'b0, 6);
    repeat (3) begin hold(1'b1, 4); hold(1'b0, 4); end
    hold(1'b0, 4);
    expect_count("en_gap_count", 3);
    expect_res("en_before", 8, 4, 1'b0, c);
    expect_res("en_after_a", 8, 4, 1'b0, c);
    expect_res("en_after_b", 8, 4, 1'b0, c);

    // Reset pulse in HIGH
    do_reset();
    hold(1'b0, 3);
    hold(1'b1, 4); hold(1'b0, 4);
    hold(1'b1, 6);
    expect_res("pre_rst", 8, 4, 1'b0, c);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.valid, bus.ovf, bus.busy, bus.period, bus.high} !== '0) begin
      errors++;
      $display("FAIL rst_mid_high got v=%b o=%b b=%b p=%0d h=%0d want all 0",
               bus.valid, bus.ovf, bus.busy, bus.period, bus.high);
    end
    hold(1'b1, 2); hold(1'b0, 4);
    repeat (3) begin hold(1'b1, 4); hold(1'b0, 4); end
    hold(1'b0, 4);
    expect_res("post_rst_partial", 6, 2, 1'b0, c);
    expect_res("post_rst_a", 8, 4, 1'b0, c);
    expect_res("post_rst_b", 8, 4, 1'b0, c);

    // Asynchronous random waveform, checked cycle by cycle against the model
    do_reset();
    hold(1'b0, 4);
    repeat (40) begin
      hi = $urandom_range(1, 20);
      lo = $urandom_range(1, 20);
      async_set(1'b1, lo);
      async_set(1'b0, hi);
    end
    hold(1'b0, 30);
    expect_count("random_count", 39);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
